// File: rtl/alu_seq.sv
// alu_seq: 16-op ALU with registered result/flags and an iterative shift-add multiplier.
// Latency: single-cycle ops visible after the accept edge; MUL after WIDTH further edges.
// Backpressure: in_ready drops while BUSY or while a held result is not consumed; no skid buffer.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_XNOR = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'ha;
  localparam logic [3:0] OP_ASR  = 4'hb;
  localparam logic [3:0] OP_ROL  = 4'hc;
  localparam logic [3:0] OP_INC  = 4'hd;
  localparam logic [3:0] OP_DEC  = 4'he;
  localparam logic [3:0] OP_MUL  = 4'hf;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, p_hi, p_lo;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] prod_hi, prod_lo;
  logic             accept, mul_start, alu_load, mul_done;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   ext;
  logic             res_c, res_v;

  assign in_ready  = rst_n && (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (sel == OP_MUL);
  assign alu_load  = accept && (sel != OP_MUL);
  assign mul_done  = (state == BUSY) && (cnt == CW'(1));

  // One shift-add step: conditionally add the multiplicand into the high half, then shift the
  // whole {carry, p_hi, p_lo} right; after WIDTH steps {p_hi, p_lo} is the full product.
  assign step_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
  assign prod_hi  = step_sum[WIDTH:1];
  assign prod_lo  = {step_sum[0], p_lo[WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mul_start) state_nxt = BUSY;
      BUSY:    if (mul_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    res   = '0;
    ext   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (sel)
      OP_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        res   = ext[WIDTH-1:0];
        res_c = ext[WIDTH];
        res_v = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        ext   = {1'b0, a} - {1'b0, b};
        res   = ext[WIDTH-1:0];
        res_c = ext[WIDTH];
        res_v = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_SHL: begin
        res   = {a[WIDTH-2:0], 1'b0};
        res_c = a[WIDTH-1];
      end
      OP_SHR: begin
        res   = {1'b0, a[WIDTH-1:1]};
        res_c = a[0];
      end
      OP_ASR: begin
        res   = {a[WIDTH-1], a[WIDTH-1:1]};
        res_c = a[0];
      end
      OP_ROL: begin
        res   = {a[WIDTH-2:0], a[WIDTH-1]};
        res_c = a[WIDTH-1];
      end
      OP_INC: begin
        res   = a + WIDTH'(1);
        res_c = &a;
        res_v = !a[WIDTH-1] && res[WIDTH-1];
      end
      OP_DEC: begin
        res   = a - WIDTH'(1);
        res_c = (a == '0);
        res_v = a[WIDTH-1] && !res[WIDTH-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      y_hi      <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (mul_start) begin
        mcand <= a;
        p_hi  <= '0;
        p_lo  <= b;
        cnt   <= CW'(WIDTH);
      end else if (state == BUSY) begin
        p_hi <= prod_hi;
        p_lo <= prod_lo;
        cnt  <= cnt - CW'(1);
      end
      if (alu_load) begin
        y      <= res;
        y_hi   <= '0;
        flag_z <= (res == '0);
        flag_c <= res_c;
        flag_n <= res[WIDTH-1];
        flag_v <= res_v;
      end else if (mul_done) begin
        y      <= prod_lo;
        y_hi   <= prod_hi;
        flag_z <= ({prod_hi, prod_lo} == '0);
        flag_c <= (prod_hi != '0);
        flag_n <= prod_lo[WIDTH-1];
        flag_v <= 1'b0;
      end
      // A result loaded on the same edge as a consumer handshake keeps out_valid high.
      if (alu_load || mul_done) out_valid <= 1'b1;
      else if (out_ready)       out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: three instances (WIDTH 4, 8, 2) driven one at a time, scoreboard-checked.
`timescale 1ns/1ps
module tb_alu_seq;
  typedef struct packed {
    logic [7:0] y;
    logic [7:0] yhi;
    logic       z, c, n, v;
  } res_t;

  typedef struct {
    res_t r;
    int   acc;
    bit   mul;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n_v     [3];
  logic       in_valid_v  [3];
  logic       in_ready_v  [3];
  logic       out_valid_v [3];
  logic       out_ready_v [3];
  logic [3:0] sel_v       [3];
  logic [7:0] a_v         [3];
  logic [7:0] b_v         [3];
  logic [7:0] y_v         [3];
  logic [7:0] yhi_v       [3];
  logic       z_v [3], c_v [3], n_v [3], vf_v [3];

  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;
  sb_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WG = (g == 0) ? 4 : (g == 1) ? 8 : 2;
    logic [WG-1:0] y_g, yhi_g;
    alu_seq #(.WIDTH(WG)) dut (
      .clk      (clk),
      .rst_n    (rst_n_v[g]),
      .in_valid (in_valid_v[g]),
      .in_ready (in_ready_v[g]),
      .sel      (sel_v[g]),
      .a        (WG'(a_v[g])),
      .b        (WG'(b_v[g])),
      .out_valid(out_valid_v[g]),
      .out_ready(out_ready_v[g]),
      .y        (y_g),
      .y_hi     (yhi_g),
      .flag_z   (z_v[g]),
      .flag_c   (c_v[g]),
      .flag_n   (n_v[g]),
      .flag_v   (vf_v[g])
    );
    assign y_v[g]   = 8'(y_g);
    assign yhi_v[g] = 8'(yhi_g);
  end

  function automatic int wd(input int d);
    return (d == 0) ? 4 : (d == 1) ? 8 : 2;
  endfunction

  function automatic int sx(input int x, input int w);
    return (x >= (1 << (w - 1))) ? x - (1 << w) : x;
  endfunction

  // Arithmetic reference: works on integers and masks to the width afterwards.
  function automatic res_t model(input int w, input logic [3:0] s, input logic [7:0] a8, input logic [7:0] b8);
    res_t r;
    int mask, ai, bi, yy, hi, sr;
    bit chk_v;
    mask = (1 << w) - 1;
    ai = int'(a8) & mask;
    bi = int'(b8) & mask;
    hi = 0; sr = 0; chk_v = 0; yy = 0;
    r = '0;
    case (s)
      4'd0:  begin yy = ai + bi; r.c = yy > mask; sr = sx(ai, w) + sx(bi, w); chk_v = 1; end
      4'd1:  begin yy = ai - bi; r.c = ai < bi;   sr = sx(ai, w) - sx(bi, w); chk_v = 1; end
      4'd2:  yy = ai & bi;
      4'd3:  yy = ai | bi;
      4'd4:  yy = ai ^ bi;
      4'd5:  yy = ~ai;
      4'd6:  yy = ~(ai & bi);
      4'd7:  yy = ~(ai | bi);
      4'd8:  yy = ~(ai ^ bi);
      4'd9:  begin yy = ai << 1; r.c = ((ai >> (w - 1)) & 1) != 0; end
      4'd10: begin yy = ai >> 1; r.c = (ai & 1) != 0; end
      4'd11: begin yy = (ai >> 1) | (ai & (1 << (w - 1))); r.c = (ai & 1) != 0; end
      4'd12: begin yy = (ai << 1) | (ai >> (w - 1)); r.c = ((ai >> (w - 1)) & 1) != 0; end
      4'd13: begin yy = ai + 1; r.c = ai == mask; sr = sx(ai, w) + 1; chk_v = 1; end
      4'd14: begin yy = ai - 1; r.c = ai == 0;    sr = sx(ai, w) - 1; chk_v = 1; end
      default: begin yy = ai * bi; hi = (yy >> w) & mask; r.c = hi != 0; end
    endcase
    yy    = yy & mask;
    r.y   = 8'(yy);
    r.yhi = 8'(hi);
    r.z   = (yy == 0) && (hi == 0);
    r.n   = ((yy >> (w - 1)) & 1) != 0;
    r.v   = chk_v && ((sr > (1 << (w - 1)) - 1) || (sr < -(1 << (w - 1))));
    return r;
  endfunction

  // Driver: offers one op with out_ready high, waits for accept and for the result.
  task automatic issue(input int d, input logic [3:0] s, input logic [7:0] a8, input logic [7:0] b8,
                       output res_t o, output int lat, output int busy, output bit ok);
    int n;
    ok = 1; lat = 0; busy = 0;
    in_valid_v[d] = 1'b1; sel_v[d] = s; a_v[d] = a8; b_v[d] = b8; out_ready_v[d] = 1'b1;
    #1;
    n = 0;
    while (!in_ready_v[d] && n < 50) begin @(posedge clk); #2; n++; end
    if (!in_ready_v[d]) ok = 0;
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
    #1;
    n = 0;
    while (!out_valid_v[d] && n < 50) begin
      if (!in_ready_v[d]) busy++;
      @(posedge clk); #2;
      lat++; n++;
    end
    if (!out_valid_v[d]) ok = 0;
    o = {y_v[d], yhi_v[d], z_v[d], c_v[d], n_v[d], vf_v[d]};
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rst_n_v[d] = 1'b0; in_valid_v[d] = 1'b0; out_ready_v[d] = 1'b1;
      sel_v[d] = 4'h0; a_v[d] = 8'h00; b_v[d] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) begin
      tests++;
      if ({out_valid_v[d], in_ready_v[d], y_v[d], yhi_v[d], z_v[d], c_v[d], n_v[d], vf_v[d]} !== 22'h0) begin
        fails++;
        $display("FAIL reset_outputs dut%0d: got ov=%b ir=%b y=%h yhi=%h zcnv=%b%b%b%b want all 0", d,
                 out_valid_v[d], in_ready_v[d], y_v[d], yhi_v[d], z_v[d], c_v[d], n_v[d], vf_v[d]);
      end
    end
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) rst_n_v[d] = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      tests++;
      if (in_ready_v[d] !== 1'b1 || out_valid_v[d] !== 1'b0) begin
        fails++;
        $display("FAIL reset_release dut%0d: got ir=%b ov=%b want ir=1 ov=0", d, in_ready_v[d], out_valid_v[d]);
      end
    end
  endtask

  task automatic test_directed();
    logic [3:0] ts [12] = '{4'h0, 4'h1, 4'h0, 4'he, 4'h4, 4'hf, 4'hf, 4'hd, 4'hd, 4'hb, 4'hc, 4'h1};
    logic [7:0] ta [12] = '{8'hf, 8'hf, 8'h7, 8'h0, 8'ha, 8'hf, 8'h0, 8'hf, 8'h7, 8'h9, 8'h9, 8'h8};
    logic [7:0] tb [12] = '{8'hc, 8'hc, 8'h1, 8'h0, 8'ha, 8'hc, 8'hf, 8'h0, 8'h0, 8'h0, 8'h0, 8'h1};
    // {y, y_hi, z c n v}
    res_t te [12] = '{{8'h0b, 8'h00, 4'b0110}, {8'h03, 8'h00, 4'b0000}, {8'h08, 8'h00, 4'b0011},
                      {8'h0f, 8'h00, 4'b0110}, {8'h00, 8'h00, 4'b1000}, {8'h04, 8'h0b, 4'b0100},
                      {8'h00, 8'h00, 4'b1000}, {8'h00, 8'h00, 4'b1100}, {8'h08, 8'h00, 4'b0011},
                      {8'h0c, 8'h00, 4'b0110}, {8'h03, 8'h00, 4'b0100}, {8'h07, 8'h00, 4'b0001}};
    res_t o;
    sb_t  e;
    int   lat, busy;
    bit   ok;
    for (int i = 0; i < 12; i++) begin
      e.r = te[i]; e.acc = 0; e.mul = (ts[i] == 4'hf);
      sbq.push_back(e);
      issue(0, ts[i], ta[i], tb[i], o, lat, busy, ok);
      e = sbq.pop_front();
      tests++;
      if (!ok || o !== e.r) begin
        fails++;
        $display("FAIL directed[%0d] sel=%h: got ok=%0b y=%h yhi=%h zcnv=%b want y=%h yhi=%h zcnv=%b", i, ts[i],
                 ok, o.y, o.yhi, {o.z, o.c, o.n, o.v}, e.r.y, e.r.yhi, {e.r.z, e.r.c, e.r.n, e.r.v});
      end
      tests++;
      if (lat !== (e.mul ? 4 : 0) || busy !== (e.mul ? 4 : 0)) begin
        fails++;
        $display("FAIL directed_latency[%0d]: got lat=%0d busy=%0d want %0d", i, lat, busy, e.mul ? 4 : 0);
      end
    end
  endtask

  task automatic test_backpressure();
    res_t o;
    res_t ex_add = {8'h0b, 8'h00, 4'b0110};
    res_t ex_sub = {8'h03, 8'h00, 4'b0000};
    sb_t  e;
    @(posedge clk); #1;
    out_ready_v[0] = 1'b0; in_valid_v[0] = 1'b1; sel_v[0] = 4'h0; a_v[0] = 8'hf; b_v[0] = 8'hc;
    e.r = ex_add; e.acc = 0; e.mul = 0;
    sbq.push_back(e);
    @(posedge clk); #1;
    sel_v[0] = 4'h1;
    for (int k = 0; k < 3; k++) begin
      #1;
      o = {y_v[0], yhi_v[0], z_v[0], c_v[0], n_v[0], vf_v[0]};
      tests++;
      if (out_valid_v[0] !== 1'b1 || in_ready_v[0] !== 1'b0 || o !== sbq[0].r) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b y=%h zcnv=%b want ov=1 ir=0 y=%h zcnv=%b", k,
                 out_valid_v[0], in_ready_v[0], o.y, {o.z, o.c, o.n, o.v}, sbq[0].r.y,
                 {sbq[0].r.z, sbq[0].r.c, sbq[0].r.n, sbq[0].r.v});
      end
      @(posedge clk); #1;
    end
    out_ready_v[0] = 1'b1;
    #1;
    tests++;
    if (in_ready_v[0] !== 1'b1) begin
      fails++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready_v[0]);
    end
    void'(sbq.pop_front());
    e.r = ex_sub;
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    #1;
    o = {y_v[0], yhi_v[0], z_v[0], c_v[0], n_v[0], vf_v[0]};
    e = sbq.pop_front();
    tests++;
    if (out_valid_v[0] !== 1'b1 || o !== e.r) begin
      fails++;
      $display("FAIL bp_swap: got ov=%b y=%h zcnv=%b want ov=1 y=%h zcnv=%b", out_valid_v[0], o.y,
               {o.z, o.c, o.n, o.v}, e.r.y, {e.r.z, e.r.c, e.r.n, e.r.v});
    end
    @(posedge clk); #2;
    tests++;
    if (out_valid_v[0] !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain: got ov=%b want 0", out_valid_v[0]);
    end
  endtask

  task automatic test_reset_mul();
    res_t o;
    sb_t  e;
    int   ghost;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b1; sel_v[0] = 4'hf; a_v[0] = 8'hf; b_v[0] = 8'hc; out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n_v[0] = 1'b0;
    #1;
    tests++;
    if ({out_valid_v[0], in_ready_v[0], y_v[0], yhi_v[0], z_v[0], c_v[0], n_v[0], vf_v[0]} !== 22'h0) begin
      fails++;
      $display("FAIL reset_mid_mul: got ov=%b ir=%b y=%h yhi=%h want all 0", out_valid_v[0], in_ready_v[0],
               y_v[0], yhi_v[0]);
    end
    @(posedge clk); #1;
    rst_n_v[0] = 1'b1;
    in_valid_v[0] = 1'b1; sel_v[0] = 4'h0; a_v[0] = 8'h7; b_v[0] = 8'h1;
    e.r = {8'h08, 8'h00, 4'b0011}; e.acc = 0; e.mul = 0;
    sbq.push_back(e);
    #1;
    tests++;
    if (in_ready_v[0] !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_ready: got %b want 1", in_ready_v[0]);
    end
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    #1;
    o = {y_v[0], yhi_v[0], z_v[0], c_v[0], n_v[0], vf_v[0]};
    e = sbq.pop_front();
    tests++;
    if (out_valid_v[0] !== 1'b1 || o !== e.r) begin
      fails++;
      $display("FAIL reset_then_add: got ov=%b y=%h zcnv=%b want ov=1 y=%h zcnv=%b", out_valid_v[0], o.y,
               {o.z, o.c, o.n, o.v}, e.r.y, {e.r.z, e.r.c, e.r.n, e.r.v});
    end
    ghost = 0;
    repeat (6) begin
      @(posedge clk); #2;
      if (out_valid_v[0] !== 1'b0) ghost++;
    end
    tests++;
    if (ghost !== 0) begin
      fails++;
      $display("FAIL reset_no_ghost: got %0d cycles of out_valid want 0", ghost);
    end
  endtask

  // mode 0: all 16 opcodes back-to-back plus a trailing ADD, out_ready=1, timing checked.
  // mode 1: random ops under random out_ready.
  task automatic test_stream(input int d, input int mode);
    logic [3:0] os[$];
    logic [7:0] oa[$], ob[$];
    int   w, mask, i, n, last_acc;
    bit   last_mul;
    sb_t  e;
    res_t o;
    w = wd(d);
    mask = (1 << w) - 1;
    if (mode == 0) begin
      for (int k = 0; k < 16; k++) begin
        os.push_back(4'(k)); oa.push_back(8'(mask)); ob.push_back(8'(mask & ~3));
      end
      os.push_back(4'h0); oa.push_back(8'h01); ob.push_back(8'h01);
    end else begin
      for (int k = 0; k < 24; k++) begin
        os.push_back(4'($urandom_range(0, 15)));
        oa.push_back(8'($urandom & mask));
        ob.push_back(8'($urandom & mask));
      end
    end
    i = 0; n = 0; last_acc = -100; last_mul = 0;
    while ((i < os.size() || sbq.size() > 0) && n < 400) begin
      @(posedge clk); #1;
      in_valid_v[d] = (i < os.size());
      if (i < os.size()) begin sel_v[d] = os[i]; a_v[d] = oa[i]; b_v[d] = ob[i]; end
      out_ready_v[d] = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      #1;
      if (out_valid_v[d]) begin
        o = {y_v[d], yhi_v[d], z_v[d], c_v[d], n_v[d], vf_v[d]};
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL stream_spurious w=%0d: out_valid with nothing expected, y=%h", w, o.y);
        end else begin
          e = sbq[0];
          if (o !== e.r) begin
            fails++;
            $display("FAIL stream_result w=%0d mode=%0d: got y=%h yhi=%h zcnv=%b want y=%h yhi=%h zcnv=%b", w, mode,
                     o.y, o.yhi, {o.z, o.c, o.n, o.v}, e.r.y, e.r.yhi, {e.r.z, e.r.c, e.r.n, e.r.v});
          end
          if (out_ready_v[d]) begin
            void'(sbq.pop_front());
            if (mode == 0) begin
              tests++;
              if (cyc - e.acc !== (e.mul ? w : 0)) begin
                fails++;
                $display("FAIL stream_latency w=%0d: got %0d edges want %0d", w, cyc - e.acc, e.mul ? w : 0);
              end
            end
          end else begin
            tests++;
            if (in_ready_v[d] !== 1'b0) begin
              fails++;
              $display("FAIL stream_stall_ready w=%0d: got %b want 0", w, in_ready_v[d]);
            end
          end
        end
      end
      if (in_valid_v[d] && in_ready_v[d]) begin
        e.r = model(w, os[i], oa[i], ob[i]); e.acc = cyc + 1; e.mul = (os[i] == 4'hf);
        sbq.push_back(e);
        if (mode == 0 && i > 0) begin
          tests++;
          if (cyc + 1 - last_acc !== (last_mul ? w + 1 : 1)) begin
            fails++;
            $display("FAIL stream_gap w=%0d: got %0d edges want %0d", w, cyc + 1 - last_acc, last_mul ? w + 1 : 1);
          end
        end
        last_acc = cyc + 1;
        last_mul = (os[i] == 4'hf);
        i++;
      end
      n++;
    end
    in_valid_v[d] = 1'b0;
    out_ready_v[d] = 1'b1;
    tests++;
    if (sbq.size() != 0 || i < os.size()) begin
      fails++;
      $display("FAIL stream_timeout w=%0d: got %0d issued, %0d pending want all done", w, i, sbq.size());
    end
    sbq.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mul();
    for (int d = 0; d < 3; d++) begin
      test_stream(d, 0);
      test_stream(d, 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
